// File: rtl/ifu_prefetch.sv
// Instruction prefetch unit: PC owner, 1-cycle ROM fetch, PC-tagged FIFO to decode.
// Optional decode-starvation counter enabled by defining IFU_PERF_CNT_EN.
module ifu_prefetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          DEPTH    = 4,
    parameter int          AW       = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic [31:0] im_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] perf_bubble
`endif
);

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic        inflight_q, inflight_d;
    logic [AW:0] count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [31:0] instr_mem_q [DEPTH];
    logic [31:0] pc_mem_q [DEPTH];
    logic        push_s, pop_s, room_s;

    // Counting the in-flight word as occupied guarantees every return finds a free slot.
    assign room_s    = ({1'b0, count_q} + {{(AW + 1){1'b0}}, inflight_q}) < (AW + 2)'(DEPTH);
    assign im_req    = !rst && !redirect && room_s;
    assign im_addr   = fetch_pc_q;
    assign out_valid = (count_q != '0);
    assign out_instr = instr_mem_q[rd_ptr_q];
    assign out_pc    = pc_mem_q[rd_ptr_q];

    // Next-state for PC, in-flight tracking and FIFO pointers; redirect flushes everything.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = 1'b0;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        push_s        = 1'b0;
        pop_s         = 1'b0;
        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            push_s = inflight_q;
            pop_s  = out_valid && out_ready;
            if (im_req) begin
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + 32'd4;
            end else begin
                inflight_d = 1'b0;
            end
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + (AW + 1)'(push_s) - (AW + 1)'(pop_s);
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= 32'h0000_0000;
            inflight_q    <= 1'b0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // FIFO storage; cleared on reset so the head outputs read zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_q[i] <= 32'h0000_0000;
                pc_mem_q[i]    <= 32'h0000_0000;
            end
        end else if (push_s) begin
            instr_mem_q[wr_ptr_q] <= im_rdata;
            pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_bubble_q, perf_bubble_d;

    // Saturating count of edges where decode had nothing to take.
    always_comb begin
        perf_bubble_d = perf_bubble_q;
        if (!out_valid && !redirect && (perf_bubble_q != 32'hFFFF_FFFF)) begin
            perf_bubble_d = perf_bubble_q + 32'd1;
        end else begin
            perf_bubble_d = perf_bubble_q;
        end
    end

    // Performance counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_bubble_q <= 32'h0000_0000;
        end else begin
            perf_bubble_q <= perf_bubble_d;
        end
    end

    assign perf_bubble = perf_bubble_q;
`endif

endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
- Instruction fetch unit that sits between the instruction memory and the decode stage of the mips core.
- Owns the architectural PC and issues sequential fetches to a 1-cycle-latency synchronous instruction ROM.
- Buffers returned words, each paired with its PC, in a small FIFO.
- Presents them to decode over a valid/ready handshake.
- Accepts a redirect (branch/jump target) that flushes all buffered and in-flight work.

Parameters:
- RESET_PC, 32'h0000_3000, first fetch address after reset.
- DEPTH, 4, prefetch FIFO entries; power of two, minimum 2.
- AW, 2, FIFO pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- im_req  output  1  fetch request to instruction memory this cycle.
- im_addr  output  32  byte address of the request; word aligned.
- im_rdata  input  32  instruction word; valid exactly one cycle after a cycle with im_req=1.
- redirect  input  1  one-cycle pulse to load a new PC and flush.
- redirect_pc  input  32  target PC; sampled when redirect=1.
- out_valid  output  1  head FIFO entry is valid.
- out_ready  input  1  decode accepts the head entry when out_valid=1.
- out_instr  output  32  instruction at the FIFO head.
- out_pc  output  32  PC of out_instr.

Behaviour:
- Reset (asynchronous, immediate):
  - fetch_pc = RESET_PC; FIFO empty; in-flight flag cleared.
  - im_req = 0, out_valid = 0, out_instr = 0, out_pc = 0.
  - Effect is the same if rst asserts mid-stream; nothing survives it.
- State: fetch_pc[31:0], FIFO count in the range 0..DEPTH, inflight bit, inflight_pc[31:0].
- Issue rule (combinational):
  - im_req = !redirect && (count + inflight < DEPTH), evaluated on the current-cycle count and inflight.
  - im_addr = fetch_pc.
  - This guarantees the FIFO never overflows; returning data always has a free slot.
- On an issue edge:
  - inflight <= 1, inflight_pc <= fetch_pc, fetch_pc <= fetch_pc + 4.
  - The increment wraps modulo 2^32; 0xFFFF_FFFC + 4 = 0x0000_0000.
- No issue and no return: inflight <= 0.
- Return: when inflight=1, {im_rdata, inflight_pc} is written into the FIFO tail on that edge. A new issue may occur in the same cycle, giving back-to-back throughput of 1 instruction per cycle.
- Dequeue: out_valid && out_ready pops the head on the edge.
  - Push and pop in the same cycle leave count unchanged.
  - Pop while full frees a slot; the issue rule uses pre-edge count, so the refill lags by one cycle.
- Head outputs: out_instr and out_pc are read from the head entry. They hold stable while out_valid=1 and out_ready=0.
- Redirect (priority over everything except reset), on the edge:
  - fetch_pc <= redirect_pc, count <= 0, read and write pointers <= 0, inflight <= 0.
  - An in-flight return in the redirect cycle is dropped.
  - A pop in the redirect cycle is ignored; decode is also flushing.
  - im_req is forced to 0 in the redirect cycle. The first fetch of redirect_pc is issued the next cycle.
  - Its instruction reaches out_valid=1 two cycles after the redirect edge.
- redirect_pc[1:0] is forced to 0; misaligned targets are truncated.
- After reset release the first im_req occurs in the first cycle with rst=0. out_valid rises on the second edge after that.

Optional Feature:
- Macro: IFU_PERF_CNT_EN.
- Defined:
  - Adds output port perf_bubble[31:0]; reset value 0.
  - Increments by 1 on every edge where out_valid=0 and redirect=0, i.e. decode was starved.
  - Saturates at 32'hFFFF_FFFF.
- Undefined: the port and counter are absent; the rest of the behaviour is identical.

Test Plan:
- Reset then out_ready=1 held, ROM word[i] = 0x2000_0000+i:
  - im_addr sequence is 0x3000, 0x3004, 0x3008, ...
  - out_pc/out_instr equal 0x3000/0x2000_0000, then 0x3004/0x2000_0001, ...
  - After the first valid, one instruction is delivered per cycle with no gaps.
- Hold out_ready=0 for 10 cycles:
  - Exactly DEPTH(4) entries are buffered and im_req drops to 0.
  - out_pc stays 0x3000.
  - On release, 0x3000..0x300C drain in order, then fetch resumes at 0x3010 with no lost or duplicated PC.
- Redirect pulse to 0x0000_4000 while the FIFO holds 3 entries and a fetch is in flight:
  - out_valid=0 the next cycle.
  - Next delivered out_pc = 0x4000 at redirect edge +2; no stale 0x30xx word appears.
- Redirect to 0xFFFF_FFFC with out_ready=1:
  - Delivered PCs are 0xFFFF_FFFC then 0x0000_0000 (wrap-around).
- Assert rst asynchronously mid-cycle while the FIFO is full:
  - out_valid and im_req fall immediately, without waiting for a clock edge.
  - After release, fetch restarts at 0x3000.
- With IFU_PERF_CNT_EN defined:
  - After reset, then 2 starved cycles, then 4 stalled-full cycles with out_ready=0: perf_bubble = 2.
  - A redirect cycle does not increment it.
